i2c_slave_ctrl: RTL and testbench
=================================

I2C_SLAVE_CTRL -- requirements
Module: i2c_slave_ctrl

Interface
REQ-001 The block SHALL have these ports (clock and reset first):
- clk  in  1  system clock
- n_rst  in  1  asynchronous, active-low reset
- start_found  in  1  single-cycle pulse, bus START detected
- stop_found  in  1  single-cycle pulse, bus STOP detected
- byte_received  in  1  single-cycle pulse, 8 bit slots completed (rx or tx)
- ack_prep  in  1  single-cycle pulse, SCL low before the ACK bit slot
- check_ack  in  1  single-cycle pulse, SCL high during the ACK bit slot
- ack_done  in  1  single-cycle pulse, SCL falling edge ending the ACK bit slot
- rw_mode  in  1  R/W bit of the address byte; 1 = master read
- address_match  in  1  address byte equals the slave address
- sda_in  in  1  synchronized SDA level
- tx_fifo_empty  in  1  transmit FIFO has no data
- rx_enable  out  1  enable receive shifting
- tx_enable  out  1  enable transmit shifting
- read_enable  out  1  pop one byte from the transmit FIFO
- load_data  out  1  load the transmit shift register
- sda_mode  out  2  00 release/high, 01 drive low (ACK), 10 drive high (NACK), 11 shift-register bit
REQ-002 Every output SHALL be a registered Moore function of the current state only.

Function
REQ-003 States: IDLE, RX_ADDR, ADDR_CHK, ACK_WAIT, ACK_DRV, NACK_DRV, LOAD, TX_BYTE, MACK_WAIT, MACK_CHK, MACK_END.
REQ-004 Global overrides, evaluated in every state before the local transitions:
- stop_found -> IDLE (highest priority)
- otherwise start_found -> RX_ADDR (repeated START)
REQ-005 IDLE: all outputs 0; start_found -> RX_ADDR.
REQ-006 RX_ADDR: rx_enable=1; byte_received -> ADDR_CHK.
REQ-007 ADDR_CHK: lasts exactly one cycle.
- address_match=1 and rw_mode=1 -> ACK_WAIT
- any other combination -> NACK_DRV
REQ-008 ACK_WAIT: sda_mode=00; ack_prep -> ACK_DRV.
REQ-009 ACK_DRV: sda_mode=01; ack_done -> LOAD.
REQ-010 NACK_DRV: sda_mode=10; ack_done -> IDLE. A later STOP or START is still handled from IDLE.
REQ-011 LOAD: lasts exactly one cycle; load_data=1; read_enable=~tx_fifo_empty; sda_mode=11; next state TX_BYTE.
REQ-012 Empty FIFO at LOAD: the shift register is loaded with its current contents and no pop occurs.
REQ-013 TX_BYTE: tx_enable=1, sda_mode=11; byte_received -> MACK_WAIT.
REQ-014 MACK_WAIT: sda_mode=00; check_ack -> MACK_CHK.
REQ-015 MACK_CHK: lasts exactly one cycle; sda_mode=00.
- sda_in=0 (master ACK) -> MACK_END
- sda_in=1 (master NACK) -> IDLE
REQ-016 MACK_END: sda_mode=00; ack_done -> LOAD.
REQ-017 Unlisted pulses (e.g. check_ack in RX_ADDR) SHALL be ignored; the state is held.
REQ-018 Output latency: an input pulse at edge N changes the outputs after edge N+1.
REQ-019 read_enable SHALL assert for at most one cycle per transmitted byte.
REQ-020 Unreachable state encodings SHALL return to IDLE on the next clock edge.

Reset
REQ-021 While n_rst=0 the block SHALL immediately enter IDLE and hold all outputs at 0, independent of clk.
REQ-022 Reset asserted mid-transfer (any state) SHALL abort the transfer.
REQ-023 After reset release, the block SHALL take no action until a new start_found.

Verification
REQ-024 Address read ACK: start_found, byte_received with address_match=1, rw_mode=1 -> ADDR_CHK, ACK_WAIT; ack_prep -> sda_mode=01; ack_done -> one-cycle load_data=1 with read_enable=1; then tx_enable=1, sda_mode=11.
REQ-025 Address mismatch and write request:
- address_match=0 -> sda_mode=10 until ack_done, then IDLE with all outputs 0
- address_match=1 with rw_mode=0 -> same response
REQ-026 Multi-byte read: three bytes, master ACK (sda_in=0 at check_ack) on the first two and NACK on the third -> exactly three read_enable pulses, then IDLE.
REQ-027 STOP mid-TX_BYTE -> IDLE next cycle, tx_enable=0. START mid-TX_BYTE -> RX_ADDR, rx_enable=1. start_found and stop_found in the same cycle -> IDLE.
REQ-028 tx_fifo_empty=1 at LOAD -> load_data=1, read_enable=0.
REQ-029 n_rst asserted in ACK_DRV -> outputs 0 without waiting for a clock edge; after release, ack_done has no effect.

Source files
------------

// File: rtl/i2c_slave_ctrl.sv
// I2C slave byte-level controller: sequences address check, ACK/NACK drive and read-data transmit.
// Outputs are registered from the current state, so they trail the state by one cycle.
module i2c_slave_ctrl (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic       byte_received,
  input  logic       ack_prep,
  input  logic       check_ack,
  input  logic       ack_done,
  input  logic       rw_mode,
  input  logic       address_match,
  input  logic       sda_in,
  input  logic       tx_fifo_empty,
  output logic       rx_enable,
  output logic       tx_enable,
  output logic       read_enable,
  output logic       load_data,
  output logic [1:0] sda_mode
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    RX_ADDR   = 4'd1,
    ADDR_CHK  = 4'd2,
    ACK_WAIT  = 4'd3,
    ACK_DRV   = 4'd4,
    NACK_DRV  = 4'd5,
    LOAD      = 4'd6,
    TX_BYTE   = 4'd7,
    MACK_WAIT = 4'd8,
    MACK_CHK  = 4'd9,
    MACK_END  = 4'd10
  } state_t;

  state_t     state_q, state_d;
  logic       rx_enable_q, rx_enable_d;
  logic       tx_enable_q, tx_enable_d;
  logic       read_enable_q, read_enable_d;
  logic       load_data_q, load_data_d;
  logic [1:0] sda_mode_q, sda_mode_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start_found) state_d = RX_ADDR;
      RX_ADDR:   if (byte_received) state_d = ADDR_CHK;
      ADDR_CHK:  state_d = (address_match && rw_mode) ? ACK_WAIT : NACK_DRV;
      ACK_WAIT:  if (ack_prep) state_d = ACK_DRV;
      ACK_DRV:   if (ack_done) state_d = LOAD;
      NACK_DRV:  if (ack_done) state_d = IDLE;
      LOAD:      state_d = TX_BYTE;
      TX_BYTE:   if (byte_received) state_d = MACK_WAIT;
      MACK_WAIT: if (check_ack) state_d = MACK_CHK;
      MACK_CHK:  state_d = sda_in ? IDLE : MACK_END;
      MACK_END:  if (ack_done) state_d = LOAD;
      default:   state_d = IDLE;
    endcase
    // Bus conditions pre-empt any local transition; STOP wins over START.
    if (stop_found) begin
      state_d = IDLE;
    end else if (start_found) begin
      state_d = RX_ADDR;
    end
  end

  always_comb begin
    rx_enable_d   = 1'b0;
    tx_enable_d   = 1'b0;
    read_enable_d = 1'b0;
    load_data_d   = 1'b0;
    sda_mode_d    = 2'b00;
    case (state_q)
      RX_ADDR:  rx_enable_d = 1'b1;
      ACK_DRV:  sda_mode_d  = 2'b01;
      NACK_DRV: sda_mode_d  = 2'b10;
      LOAD: begin
        // With an empty FIFO the shifter reloads its own contents; no pop.
        load_data_d   = 1'b1;
        read_enable_d = ~tx_fifo_empty;
        sda_mode_d    = 2'b11;
      end
      TX_BYTE: begin
        tx_enable_d = 1'b1;
        sda_mode_d  = 2'b11;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      rx_enable_q   <= 1'b0;
      tx_enable_q   <= 1'b0;
      read_enable_q <= 1'b0;
      load_data_q   <= 1'b0;
      sda_mode_q    <= 2'b00;
    end else begin
      state_q       <= state_d;
      rx_enable_q   <= rx_enable_d;
      tx_enable_q   <= tx_enable_d;
      read_enable_q <= read_enable_d;
      load_data_q   <= load_data_d;
      sda_mode_q    <= sda_mode_d;
    end
  end

  assign rx_enable   = rx_enable_q;
  assign tx_enable   = tx_enable_q;
  assign read_enable = read_enable_q;
  assign load_data   = load_data_q;
  assign sda_mode    = sda_mode_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench for i2c_slave_ctrl; outputs packed as {rx,tx,read,load,sda[1:0]}.
module tb_i2c_slave_ctrl;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start_found = 1'b0, stop_found = 1'b0, byte_received = 1'b0;
  logic ack_prep = 1'b0, check_ack = 1'b0, ack_done = 1'b0;
  logic rw_mode = 1'b0, address_match = 1'b0, sda_in = 1'b0, tx_fifo_empty = 1'b0;
  logic rx_enable, tx_enable, read_enable, load_data;
  logic [1:0] sda_mode;
  logic [5:0] outs;
  int total = 0;
  int bad = 0;
  int re_cnt = 0;

  assign outs = {rx_enable, tx_enable, read_enable, load_data, sda_mode};

  always #5 clk = ~clk;

  always @(negedge clk) if (read_enable === 1'b1) re_cnt++;

  i2c_slave_ctrl dut (
    .clk(clk), .n_rst(n_rst),
    .start_found(start_found), .stop_found(stop_found), .byte_received(byte_received),
    .ack_prep(ack_prep), .check_ack(check_ack), .ack_done(ack_done),
    .rw_mode(rw_mode), .address_match(address_match), .sda_in(sda_in),
    .tx_fifo_empty(tx_fifo_empty),
    .rx_enable(rx_enable), .tx_enable(tx_enable), .read_enable(read_enable),
    .load_data(load_data), .sda_mode(sda_mode)
  );

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Drives a read-address transaction; returns at the negedge where the LOAD outputs are visible.
  task automatic to_load(input logic empty);
    address_match = 1'b1; rw_mode = 1'b1;
    start_found = 1'b1; step(); start_found = 1'b0; step();
    byte_received = 1'b1; step(); byte_received = 1'b0; step();
    ack_prep = 1'b1; step(); ack_prep = 1'b0; step();
    tx_fifo_empty = empty;
    ack_done = 1'b1; step(); ack_done = 1'b0; step();
  endtask

  task automatic stop_bus();
    stop_found = 1'b1; step(); stop_found = 1'b0; step();
    tx_fifo_empty = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (outs !== 6'b000000) begin bad++; $display("FAIL reset_async got=%b exp=000000", outs); end
    start_found = 1'b1; step(); start_found = 1'b0; step();
    total++;
    if (outs !== 6'b000000) begin bad++; $display("FAIL reset_hold got=%b exp=000000", outs); end
    n_rst = 1'b1; step(2);
    total++;
    if (outs !== 6'b000000) begin bad++; $display("FAIL reset_release_idle got=%b exp=000000", outs); end
  endtask

  task automatic test_addr_ack();
    address_match = 1'b1; rw_mode = 1'b1;
    start_found = 1'b1; step(); start_found = 1'b0; step();
    total++;
    if (outs !== 6'b100000) begin bad++; $display("FAIL ack_rx_addr got=%b exp=100000", outs); end
    byte_received = 1'b1; step(); byte_received = 1'b0; step();
    total++;
    if (outs !== 6'b000000) begin bad++; $display("FAIL ack_addr_chk got=%b exp=000000", outs); end
    ack_prep = 1'b1; step(); ack_prep = 1'b0; step();
    total++;
    if (outs !== 6'b000001) begin bad++; $display("FAIL ack_drive_low got=%b exp=000001", outs); end
    ack_done = 1'b1; step(); ack_done = 1'b0; step();
    total++;
    if (outs !== 6'b001111) begin bad++; $display("FAIL ack_load got=%b exp=001111", outs); end
    step();
    total++;
    if (outs !== 6'b010011) begin bad++; $display("FAIL ack_tx_byte got=%b exp=010011", outs); end
    stop_bus();
  endtask

  task automatic test_nack(input logic am, input logic rw);
    address_match = am; rw_mode = rw;
    start_found = 1'b1; step(); start_found = 1'b0; step();
    byte_received = 1'b1; step(); byte_received = 1'b0; step(2);
    total++;
    if (outs !== 6'b000010) begin bad++; $display("FAIL nack_drive am=%b rw=%b got=%b exp=000010", am, rw, outs); end
    ack_done = 1'b1; step(); ack_done = 1'b0; step();
    total++;
    if (outs !== 6'b000000) begin bad++; $display("FAIL nack_idle am=%b rw=%b got=%b exp=000000", am, rw, outs); end
  endtask

  task automatic test_multi_read();
    int base;
    base = re_cnt;
    to_load(1'b0); step();
    for (int b = 0; b < 3; b++) begin
      byte_received = 1'b1; step(); byte_received = 1'b0; step();
      check_ack = 1'b1; sda_in = (b == 2); step(); check_ack = 1'b0; step();
      sda_in = 1'b0;
      if (b < 2) begin
        ack_done = 1'b1; step(); ack_done = 1'b0; step(2);
      end else begin
        step(2);
      end
    end
    total++;
    if (re_cnt - base !== 3) begin bad++; $display("FAIL multi_read_pops got=%0d exp=3", re_cnt - base); end
    total++;
    if (outs !== 6'b000000) begin bad++; $display("FAIL multi_read_idle got=%b exp=000000", outs); end
  endtask

  task automatic test_bus_overrides();
    to_load(1'b0); step();
    stop_found = 1'b1; step(); stop_found = 1'b0; step();
    total++;
    if (outs !== 6'b000000) begin bad++; $display("FAIL stop_in_tx got=%b exp=000000", outs); end
    to_load(1'b0); step();
    start_found = 1'b1; step(); start_found = 1'b0; step();
    total++;
    if (outs !== 6'b100000) begin bad++; $display("FAIL restart_in_tx got=%b exp=100000", outs); end
    stop_bus();
    to_load(1'b0); step();
    start_found = 1'b1; stop_found = 1'b1; step(); start_found = 1'b0; stop_found = 1'b0; step();
    total++;
    if (outs !== 6'b000000) begin bad++; $display("FAIL start_stop_same got=%b exp=000000", outs); end
  endtask

  task automatic test_empty_fifo();
    to_load(1'b1);
    total++;
    if (outs !== 6'b000111) begin bad++; $display("FAIL empty_load got=%b exp=000111", outs); end
    stop_bus();
  endtask

  task automatic test_ignore();
    start_found = 1'b1; step(); start_found = 1'b0; step();
    check_ack = 1'b1; ack_prep = 1'b1; ack_done = 1'b1; step();
    check_ack = 1'b0; ack_prep = 1'b0; ack_done = 1'b0; step(2);
    total++;
    if (outs !== 6'b100000) begin bad++; $display("FAIL ignore_in_rx got=%b exp=100000", outs); end
    stop_bus();
  endtask

  task automatic test_reset_mid();
    address_match = 1'b1; rw_mode = 1'b1;
    start_found = 1'b1; step(); start_found = 1'b0; step();
    byte_received = 1'b1; step(); byte_received = 1'b0; step();
    ack_prep = 1'b1; step(); ack_prep = 1'b0; step();
    total++;
    if (outs !== 6'b000001) begin bad++; $display("FAIL mid_pre_reset got=%b exp=000001", outs); end
    #2 n_rst = 1'b0;
    #1;
    total++;
    if (outs !== 6'b000000) begin bad++; $display("FAIL mid_async_reset got=%b exp=000000", outs); end
    step(2); n_rst = 1'b1; step();
    ack_done = 1'b1; step(); ack_done = 1'b0; step(3);
    total++;
    if (outs !== 6'b000000) begin bad++; $display("FAIL mid_after_release got=%b exp=000000", outs); end
  endtask

  initial begin
    test_reset();
    test_addr_ack();
    test_nack(1'b0, 1'b1);
    test_nack(1'b1, 1'b0);
    test_multi_read();
    test_bus_overrides();
    test_empty_fifo();
    test_ignore();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
